sphy_lanes: RTL and testbench

SPHY_LANES -- requirements
Module: sphy_lanes

---
 rtl/sphy_lanes.sv | 213 +++++++++++++++++++++
 tb/tb_sphy_lanes.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sphy_lanes.sv
// Multi-lane SPI (mode 0) pad front end: synchronizers, IDLE/ACTIVE session FSM, byte shifter and TX holding register.
// Optional: define SPHY_TX_UNDERRUN_CNT_EN to add tx_unf_cnt (saturating count of 0xFF underrun reloads).
module sphy_lanes #(
  parameter int LANES       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic             p_ck,
  input  logic             p_ncs,
  input  logic [LANES-1:0] p_si,
  output logic [LANES-1:0] p_so,
  output logic [LANES-1:0] p_se,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic             sel,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready
`ifdef SPHY_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]       tx_unf_cnt
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Clamp requested width to what the pad count supports
  function automatic logic [1:0] f_eff(input logic [1:0] m);
    f_eff = m;
    if (f_eff == 2'd3 && LANES < 8) f_eff = 2'd2;
    if (f_eff == 2'd2 && LANES < 4) f_eff = 2'd1;
  endfunction

  function automatic logic [LANES-1:0] f_grp(input logic [7:0] v, input logic [1:0] m, input logic d);
    logic [3:0] k;
    logic [7:0] t;
    k     = 4'd1 << m;
    t     = v >> (4'd8 - k);
    f_grp = '0;
    if (m == 2'd0) f_grp[1] = v[7];
    else if (d) begin
      for (int j = 0; j < LANES; j++)
        if (j < int'(k)) f_grp[j] = t[3'(j)];
    end
  endfunction

  function automatic logic [LANES-1:0] f_se(input logic [1:0] m, input logic d);
    logic [3:0] k;
    k    = 4'd1 << m;
    f_se = '0;
    if (m == 2'd0) f_se[1] = 1'b1;
    else if (d) begin
      for (int j = 0; j < LANES; j++)
        if (j < int'(k)) f_se[j] = 1'b1;
    end
  endfunction

  logic [SYNC_STAGES-1:0]            r_ck_s, r_ncs_s;
  logic [SYNC_STAGES-1:0][LANES-1:0] r_si_s;
  logic                              r_ck_d, r_ncs_d;
  logic                              w_ck, w_ncs;
  logic [LANES-1:0]                  w_si;

  always_ff @(posedge ck) begin
    if (!nrst) begin
      r_ck_s  <= '0;
      r_ncs_s <= '1;
      r_si_s  <= '0;
      r_ck_d  <= 1'b0;
      r_ncs_d <= 1'b1;
    end else begin
      r_ck_s  <= {r_ck_s[SYNC_STAGES-2:0], p_ck};
      r_ncs_s <= {r_ncs_s[SYNC_STAGES-2:0], p_ncs};
      r_si_s  <= {r_si_s[SYNC_STAGES-2:0], p_si};
      r_ck_d  <= w_ck;
      r_ncs_d <= w_ncs;
    end
  end

  assign w_ck  = r_ck_s[SYNC_STAGES-1];
  assign w_ncs = r_ncs_s[SYNC_STAGES-1];
  assign w_si  = r_si_s[SYNC_STAGES-1];

  state_t           r_state, w_state_nxt;
  logic             w_start, w_stop;
  logic [1:0]       r_meff;
  logic             r_dir;
  logic [3:0]       r_cnt, w_cnt_nxt, w_k;
  logic [7:0]       r_sh, w_sh_nxt, r_rx, w_gin, w_asm;
  logic             r_fresh;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic [LANES-1:0] r_so, r_se;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic             w_samp, w_shft, w_done, w_reload, w_acc, w_rxing;
  logic [7:0]       w_reload_val;
  logic [1:0]       w_meff_in;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      IDLE:   if (!w_ncs && r_ncs_d) begin w_state_nxt = ACTIVE; w_start = 1'b1; end
      ACTIVE: if (w_ncs)             begin w_state_nxt = IDLE;   w_stop  = 1'b1; end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gin = '0;
    for (int j = 0; j < LANES; j++)
      if (j < int'(w_k)) w_gin[3'(j)] = w_si[j];
  end

  assign w_meff_in    = f_eff(mode);
  assign w_k          = 4'd1 << r_meff;
  assign w_cnt_nxt    = r_cnt + w_k;
  assign w_sh_nxt     = r_sh << w_k;
  assign w_asm        = (r_rx << w_k) | w_gin;
  assign w_samp       = (r_state == ACTIVE) && !w_ncs && w_ck && !r_ck_d;
  assign w_shft       = (r_state == ACTIVE) && !w_ncs && !w_ck && r_ck_d;
  assign w_done       = w_samp && (w_cnt_nxt == 4'd8);
  assign w_reload     = w_start || w_done;
  assign w_reload_val = r_hold_full ? r_hold : 8'hFF;
  assign w_acc        = tx_valid && !r_hold_full;
  assign w_rxing      = (r_meff == 2'd0) || !r_dir;

  always_ff @(posedge ck) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_meff      <= 2'd0;
      r_dir       <= 1'b0;
      r_cnt       <= 4'd0;
      r_sh        <= 8'd0;
      r_fresh     <= 1'b0;
      r_rx        <= 8'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_so        <= '0;
      r_se        <= '0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_valid <= 1'b0;
      if (w_start) begin
        r_meff  <= w_meff_in;
        r_dir   <= dir;
        r_cnt   <= 4'd0;
        r_rx    <= 8'd0;
        r_sh    <= w_reload_val;
        r_fresh <= 1'b0;
        r_so    <= f_grp(w_reload_val, w_meff_in, dir);
        r_se    <= f_se(w_meff_in, dir);
      end else if (w_stop) begin
        r_so  <= '0;
        r_se  <= '0;
        r_cnt <= 4'd0;
      end else begin
        if (w_samp) begin
          r_cnt <= w_done ? 4'd0 : w_cnt_nxt;
          r_rx  <= w_asm;
          if (w_done) begin
            if (w_rxing) begin
              r_rx_data  <= w_asm;
              r_rx_valid <= 1'b1;
            end
            r_sh    <= w_reload_val;
            r_fresh <= 1'b1;
          end
        end
        // After a reload the new byte's first group is already on top of the shifter
        if (w_shft) begin
          if (r_fresh) begin
            r_so    <= f_grp(r_sh, r_meff, r_dir);
            r_fresh <= 1'b0;
          end else begin
            r_sh <= w_sh_nxt;
            r_so <= f_grp(w_sh_nxt, r_meff, r_dir);
          end
        end
      end
      if (w_acc) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_reload && r_hold_full) begin
        r_hold_full <= 1'b0;
      end
    end
  end

`ifdef SPHY_TX_UNDERRUN_CNT_EN
  logic [7:0] r_unf;
  always_ff @(posedge ck) begin
    if (!nrst) r_unf <= 8'd0;
    else if (w_reload && !r_hold_full && r_unf != 8'hFF) r_unf <= r_unf + 8'd1;
  end
  assign tx_unf_cnt = r_unf;
`endif

  assign sel      = (r_state == ACTIVE);
  assign p_so     = r_so;
  assign p_se     = r_se;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_ready = !r_hold_full;

endmodule

// File: tb/tb_sphy_lanes.sv
// Table-driven bench for sphy_lanes (LANES=4): session vectors plus abort/reset sequences, RX checked via scoreboard queue.
module tb_sphy_lanes;
  localparam int LANES = 4;

  logic             ck = 1'b0, nrst = 1'b0, p_ck = 1'b0, p_ncs = 1'b1;
  logic [LANES-1:0] p_si = '0, p_so, p_se;
  logic [1:0]       mode = 2'd0;
  logic             dir = 1'b0, sel, rx_valid, tx_valid = 1'b0, tx_ready;
  logic [7:0]       rx_data, tx_data = 8'd0;
`ifdef SPHY_TX_UNDERRUN_CNT_EN
  logic [7:0]       tx_unf_cnt;
  int               exp_unf = 0;
`endif

  sphy_lanes #(.LANES(LANES), .SYNC_STAGES(2)) dut (
    .ck(ck), .nrst(nrst), .p_ck(p_ck), .p_ncs(p_ncs), .p_si(p_si), .p_so(p_so), .p_se(p_se),
    .mode(mode), .dir(dir), .sel(sel), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef SPHY_TX_UNDERRUN_CNT_EN
    , .tx_unf_cnt(tx_unf_cnt)
`endif
  );

  always #5 ck = ~ck;

  int         errs = 0, chks = 0;
  logic [7:0] rxq[$];

  typedef struct {
    logic [1:0]      mode;
    logic            dir;
    int              n;
    logic [2:0][7:0] tx;
    logic [2:0]      txv;
    logic [2:0][7:0] si;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge ck) begin
    if (nrst && rx_valid) begin
      if (rxq.size() == 0) check("unexpected rx_valid", 32'd1, 32'd0);
      else check("rx_data", {24'd0, rx_data}, {24'd0, rxq.pop_front()});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge ck);
  endtask

  function automatic int eff(input logic [1:0] m);
    return (m == 2'd3) ? 2 : int'(m);
  endfunction

  function automatic logic [3:0] grp(input logic [7:0] b, input int k, input int g);
    int t;
    t = int'(b);
    t = (t >> (8 - k * (g + 1))) & ((1 << k) - 1);
    return t[3:0];
  endfunction

  task automatic offer(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 40) begin cyc(1); t++; end
    check("tx_ready before load", {31'd0, tx_ready}, 32'd1);
    tx_data = b; tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    check("tx_ready after load", {31'd0, tx_ready}, 32'd0);
  endtask

  task automatic pulse(input logic [3:0] si);
    p_si = si;
    cyc(3); p_ck = 1'b1;
    cyc(6); p_ck = 1'b0;
    cyc(6);
  endtask

  task automatic session(input vec_t v, input logic skip0);
    int m, k, gs, tot, idx;
    logic rx_en, tx_en;
    logic [3:0] msk, exp_so, exp_se;
    logic [7:0] txb[3];
    m = eff(v.mode); k = 1 << m; gs = 8 / k; tot = v.n * gs;
    rx_en = (m == 0) || !v.dir;
    tx_en = (m == 0) || v.dir;
    msk    = (m == 0) ? 4'b0010 : (v.dir ? 4'((1 << k) - 1) : 4'b0000);
    exp_se = msk;
    for (int b = 0; b < 3; b++) txb[b] = v.txv[b] ? v.tx[b] : 8'hFF;
    if (v.txv[0] && !skip0) offer(v.tx[0]);
    mode = v.mode; dir = v.dir; p_ncs = 1'b0;
    cyc(8);
    mode = ~v.mode; dir = ~v.dir;
    check("sel active", {31'd0, sel}, 32'd1);
    check("p_se active", {28'd0, p_se}, {28'd0, exp_se});
    if (tx_en) begin
      exp_so = (m == 0) ? {grp(txb[0], k, 0), 1'b0} : grp(txb[0], k, 0);
      check("p_so first group", {28'd0, p_so & msk}, {28'd0, exp_so & msk});
    end
    for (int b = 0; b < v.n; b++) begin
      if (b + 1 < v.n && v.txv[b+1]) offer(v.tx[b+1]);
      if (rx_en) rxq.push_back(v.si[b]);
`ifdef SPHY_TX_UNDERRUN_CNT_EN
      if (!v.txv[b] && exp_unf < 255) exp_unf++;
`endif
      for (int g = 0; g < gs; g++) begin
        pulse(grp(v.si[b], k, g));
        idx = b * gs + g + 1;
        if (idx < tot && tx_en) begin
          exp_so = grp(txb[idx / gs], k, idx % gs);
          if (m == 0) exp_so = {exp_so[2:0], 1'b0};
          check("p_so group", {28'd0, p_so & msk}, {28'd0, exp_so & msk});
        end
      end
    end
`ifdef SPHY_TX_UNDERRUN_CNT_EN
    if (exp_unf < 255) exp_unf++;
`endif
    cyc(4);
    p_ncs = 1'b1;
    cyc(8);
    mode = 2'd0; dir = 1'b0;
    check("sel idle", {31'd0, sel}, 32'd0);
    check("p_se idle", {28'd0, p_se}, 32'd0);
    check("rx queue drained", rxq.size(), 32'd0);
`ifdef SPHY_TX_UNDERRUN_CNT_EN
    check("tx_unf_cnt", {24'd0, tx_unf_cnt}, exp_unf);
`endif
  endtask

  task automatic check_reset_state();
    check("rst sel", {31'd0, sel}, 32'd0);
    check("rst p_se", {28'd0, p_se}, 32'd0);
    check("rst p_so", {28'd0, p_so}, 32'd0);
    check("rst rx_data", {24'd0, rx_data}, 32'd0);
    check("rst rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst tx_ready", {31'd0, tx_ready}, 32'd1);
`ifdef SPHY_TX_UNDERRUN_CNT_EN
    check("rst tx_unf_cnt", {24'd0, tx_unf_cnt}, 32'd0);
`endif
  endtask

  initial begin
    vec_t fu;
    tbl[0] = '{2'd0, 1'b0, 1, {8'h00, 8'h00, 8'hA5}, 3'b001, {8'h00, 8'h00, 8'h3C}};
    tbl[1] = '{2'd2, 1'b1, 2, {8'h00, 8'hC3, 8'h5A}, 3'b011, {8'h00, 8'h00, 8'h00}};
    tbl[2] = '{2'd2, 1'b0, 1, {8'h00, 8'h00, 8'h00}, 3'b000, {8'h00, 8'h00, 8'h96}};
    tbl[3] = '{2'd1, 1'b0, 1, {8'h00, 8'h00, 8'h00}, 3'b000, {8'h00, 8'h00, 8'hE1}};
    tbl[4] = '{2'd1, 1'b1, 1, {8'h00, 8'h00, 8'h9C}, 3'b001, {8'h00, 8'h00, 8'h00}};
    tbl[5] = '{2'd3, 1'b1, 1, {8'h00, 8'h00, 8'h7E}, 3'b001, {8'h00, 8'h00, 8'h00}};
    tbl[6] = '{2'd0, 1'b0, 2, {8'h00, 8'h00, 8'h00}, 3'b000, {8'h00, 8'h42, 8'h81}};
    tbl[7] = '{2'd3, 1'b0, 1, {8'h00, 8'h00, 8'h00}, 3'b000, {8'h00, 8'h00, 8'h5F}};

    cyc(3);
    check_reset_state();
    nrst = 1'b1;
    cyc(8);

    for (int i = 0; i < 8; i++) session(tbl[i], 1'b0);

    // Abort after 5 bits: no rx_valid, holding byte survives for the next session
    p_ncs = 1'b0; cyc(8);
    offer(8'h66);
    for (int i = 0; i < 5; i++) pulse(4'(i & 1));
`ifdef SPHY_TX_UNDERRUN_CNT_EN
    exp_unf++;
`endif
    p_ncs = 1'b1; cyc(8);
    check("abort p_se", {28'd0, p_se}, 32'd0);
    check("abort sel", {31'd0, sel}, 32'd0);
    check("abort holding kept", {31'd0, tx_ready}, 32'd0);
    fu = '{2'd0, 1'b0, 1, {8'h00, 8'h00, 8'h66}, 3'b001, {8'h00, 8'h00, 8'hC7}};
    session(fu, 1'b1);

    // Reset mid-byte with a full holding register
    p_ncs = 1'b0; cyc(8);
    offer(8'h11);
    for (int i = 0; i < 3; i++) pulse(4'd1);
    nrst = 1'b0; p_ncs = 1'b1;
    cyc(1);
    check_reset_state();
    cyc(2);
    nrst = 1'b1;
`ifdef SPHY_TX_UNDERRUN_CNT_EN
    exp_unf = 0;
`endif
    cyc(8);

`ifdef SPHY_TX_UNDERRUN_CNT_EN
    mode = 2'd2; dir = 1'b1; p_ncs = 1'b0;
    cyc(8);
    for (int i = 0; i < 600; i++) begin
      p_ck = 1'b1; cyc(4);
      p_ck = 1'b0; cyc(4);
    end
    cyc(4);
    check("tx_unf_cnt saturated", {24'd0, tx_unf_cnt}, 32'd255);
    p_ncs = 1'b1; cyc(8);
`endif

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
